serial_adder: RTL and testbench

Bit-serial N-bit adder built around the existing single-bit `full_adder` cell. It accepts two parallel operands and a carry-in over a valid/ready handshake. It computes the sum LSB-first, one bit per clock, holding the carry in a flip-flop between bits. It presents the parallel sum and final carry on an output valid/ready handshake. It sits directly downstream of the operand source and reuses `full_adder` as its datapath, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/full_adder.sv | 21 ++
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM state type and default width for serial_adder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADDER_WIDTH = 8;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with
//               valid/ready handshakes. SERIAL_ADDER_SUB_EN adds a `sub` input.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int                   c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_fa_sum;
    logic               w_fa_carry;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;
    logic               w_accept;

    // Subtraction is a + ~b + 1, so it only changes what is loaded at accept
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : carry_in;
`else
    assign w_b_load     = b;
    assign w_carry_load = carry_in;
`endif

    assign w_accept = in_valid & in_ready;

    full_adder u_full_adder (
        .a         (r_a[0]),
        .b         (r_b[0]),
        .carry_in  (r_carry),
        .sum       (w_fa_sum),
        .carry_out (w_fa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the first one computed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_carry_load;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_carry <= w_fa_carry;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder (WIDTH=8), random and
//               directed operands; sub cases when SERIAL_ADDER_SUB_EN is set.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int c_width = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [c_width-1:0] a = '0;
    logic [c_width-1:0] b = '0;
    logic               carry_in = 1'b0;
    logic               sub = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [c_width-1:0] sum;
    logic               carry_out;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(c_width)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; subtraction reports "no borrow"
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        int unsigned r;
        logic [7:0]  d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        r = x + y + c;
        return r[8:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: result transfer happens at the next posedge when valid&ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got %0h expected none", {carry_out, sum});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({carry_out, sum} !== e) begin
                    errors++;
                    $display("FAIL result: got %0h expected %0h", {carry_out, sum}, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic ts, input int bp);
        int n;
        logic [8:0] e;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a = ta; b = tb_v; carry_in = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        e = model(ta, tb_v, tc, sub);
        exp_q.push_back(e);
        @(posedge clk); #1;
        n = 0;
        // junk on the input side while busy must be ignored
        while (!out_valid && n < 64) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom);
            carry_in = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(c_width));
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'(e[7:0]));
            check("bp_carry", 32'(carry_out), 32'(e[8]));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_handshake_valid", 32'(out_valid), 32'd0);
        check("post_handshake_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_carry"}, 32'(carry_out), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        send(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        send(8'h12, 8'h34, 1'b0, 1'b0, 0);
        send(8'h00, 8'h00, 1'b0, 1'b0, 0);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        send(8'h80, 8'h80, 1'b0, 1'b0, 5);

        // Abort in the 4th RUN cycle
        a = 8'h55; b = 8'h66; carry_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_valid_after", 32'(out_valid), 32'd0);
        send(8'h03, 8'h04, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        send(8'h05, 8'h07, 1'b0, 1'b1, 0);
        send(8'h07, 8'h05, 1'b1, 1'b1, 0);
        send(8'h00, 8'h00, 1'b0, 1'b1, 0);
`endif

        for (int t = 0; t < 24; t++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            send(8'($urandom), 8'($urandom), 1'($urandom), s, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
